mc_ctrl_fsm: RTL and testbench

//  Multicycle MIPS-subset control unit; the stage directly upstream of the datapath mux library.

---
 rtl/mc_defs.sv | 89 ++++++++
 rtl/mc_ctrl_fsm_if.sv | 38 +++
 rtl/mc_ctrl_decode.sv | 85 ++++++++
 rtl/mc_ctrl_fsm.sv | 76 +++++++
 tb/tb_mc_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_defs.sv
// Shared definitions for the multicycle control unit and the datapath mux library:
// opcode constants, state encodings, mux-select encodings and the control word.
package mc_defs;

  localparam int OPW = 6;  // opcode width
  localparam int STW = 4;  // state register width

  // Supported instr[31:26] values
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  // Encodings 14 and 15 are unused and recover to S_IDLE
  typedef enum logic [STW-1:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC    = 4'd3,
    S_ALUWB   = 4'd4,
    S_MEMADR  = 4'd5,
    S_MEMRD   = 4'd6,
    S_MEMWB   = 4'd7,
    S_MEMWR   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  // 4:1 ALU B-operand select
  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  // 3:1 PC source select; 2'b11 is never driven
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

  // ALU operation class; 2'b11 is never driven
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // Raw per-state control word, before mem_ready / zero gating
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    pc_src_e    pc_src;
    alu_op_e    alu_op;
    logic       illegal;
  } ctrl_word_t;

  // First execute-phase state for an opcode seen in DECODE
  function automatic state_e dispatch_state(input logic [OPW-1:0] op);
    state_e st;
    st = S_ILLEGAL;
    case (op)
      OP_RTYPE:     st = S_EXEC;
      OP_LW, OP_SW: st = S_MEMADR;
      OP_BEQ:       st = S_BRANCH;
      OP_ADDI:      st = S_ADDIEX;
      OP_J:         st = S_JUMP;
      default:      st = S_ILLEGAL;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control-unit <-> datapath bus: status inputs to the FSM and every mux select / enable.
interface mc_ctrl_fsm_if #(
  parameter int OPW = mc_defs::OPW
);

  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;

  logic           pc_en;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     pc_src;
  logic [1:0]     alu_op;
  logic           illegal;

  // Control unit side
  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal
  );

  // Datapath side
  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word table (Moore part of the control unit).
module mc_ctrl_decode
  import mc_defs::*;
(
  input  state_e     i_state,
  output ctrl_word_t o_cw
);

  // Per-state control word; anything not listed for a state stays 0
  always_comb begin
    // NOTE: the all-zero default comes first so every state, including unused
    // encodings, assigns every field and no latch is inferred.
    o_cw = '0;
    case (i_state)
      S_FETCH: begin
        o_cw.mem_read  = 1'b1;
        o_cw.ir_write  = 1'b1;
        o_cw.pc_write  = 1'b1;
        o_cw.alu_src_a = 1'b0;
        o_cw.alu_src_b = SRCB_FOUR;
        o_cw.alu_op    = ALUOP_ADD;
        o_cw.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        o_cw.alu_src_a = 1'b0;
        o_cw.alu_src_b = SRCB_IMM_SH2;
        o_cw.alu_op    = ALUOP_ADD;
      end
      S_EXEC: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_REG;
        o_cw.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_cw.reg_dst    = 1'b1;
        o_cw.mem_to_reg = 1'b0;
        o_cw.reg_write  = 1'b1;
      end
      S_MEMADR: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
        o_cw.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_cw.iord     = 1'b1;
        o_cw.mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_cw.reg_dst    = 1'b0;
        o_cw.mem_to_reg = 1'b1;
        o_cw.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_cw.iord      = 1'b1;
        o_cw.mem_write = 1'b1;
      end
      S_BRANCH: begin
        o_cw.alu_src_a     = 1'b1;
        o_cw.alu_src_b     = SRCB_REG;
        o_cw.alu_op        = ALUOP_SUB;
        o_cw.pc_src        = PCSRC_ALUOUT;
        o_cw.pc_write_cond = 1'b1;
      end
      S_ADDIEX: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
        o_cw.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        o_cw.reg_dst    = 1'b0;
        o_cw.mem_to_reg = 1'b0;
        o_cw.reg_write  = 1'b1;
      end
      S_JUMP: begin
        o_cw.pc_src   = PCSRC_JUMP;
        o_cw.pc_write = 1'b1;
      end
      S_ILLEGAL: begin
        o_cw.illegal = 1'b1;
      end
      default: o_cw = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control unit: state register, next-state logic,
// memory-ready stall gating and the pc_en branch gate.
module mc_ctrl_fsm
  import mc_defs::*;
(
  input  logic            clk,
  input  logic            reset_n,
  mc_ctrl_fsm_if.master   bus
);

  state_e     r_state;
  state_e     w_next_state;
  logic       r_is_store;    // LW/SW choice remembered from DECODE
  ctrl_word_t w_cw;
  logic       w_fetch_stall;
  logic       w_pc_write;

  mc_ctrl_decode u_decode (
    .i_state (r_state),
    .o_cw    (w_cw)
  );

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop in the design samples pre-edge values.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Opcode is only valid in DECODE, so the load/store choice is latched there for MEMADR
  always_ff @(posedge clk) begin
    if (!reset_n)                 r_is_store <= 1'b0;
    else if (r_state == S_DECODE) r_is_store <= (bus.opcode == OP_SW);
  end

  // Next-state: memory states hold until mem_ready, DECODE dispatches on opcode
  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:    w_next_state = S_FETCH;
      S_FETCH:   w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next_state = dispatch_state(bus.opcode);
      S_EXEC:    w_next_state = S_ALUWB;
      S_ALUWB:   w_next_state = S_FETCH;
      S_MEMADR:  w_next_state = r_is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next_state = S_FETCH;
      S_MEMWR:   w_next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_BRANCH:  w_next_state = S_FETCH;
      S_ADDIEX:  w_next_state = S_ADDIWB;
      S_ADDIWB:  w_next_state = S_FETCH;
      S_JUMP:    w_next_state = S_FETCH;
      S_ILLEGAL: w_next_state = S_FETCH;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // IR load and PC+4 update must not fire while the fetch is still outstanding
  assign w_fetch_stall = (r_state == S_FETCH) && !bus.mem_ready;
  assign w_pc_write    = w_cw.pc_write && !w_fetch_stall;

  assign bus.pc_en      = w_pc_write | (w_cw.pc_write_cond & bus.zero);
  assign bus.ir_write   = w_cw.ir_write && !w_fetch_stall;
  assign bus.iord       = w_cw.iord;
  assign bus.mem_read   = w_cw.mem_read;
  assign bus.mem_write  = w_cw.mem_write;
  assign bus.reg_dst    = w_cw.reg_dst;
  assign bus.mem_to_reg = w_cw.mem_to_reg;
  assign bus.reg_write  = w_cw.reg_write;
  assign bus.alu_src_a  = w_cw.alu_src_a;
  assign bus.alu_src_b  = w_cw.alu_src_b;
  assign bus.pc_src     = w_cw.pc_src;
  assign bus.alu_op     = w_cw.alu_op;
  assign bus.illegal    = w_cw.illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: an instruction-level step model checked every
// cycle, plus hand-computed probes on the directed sequences.
module tb_mc_ctrl_fsm;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  mc_ctrl_fsm_if bus ();

  mc_ctrl_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
  //  alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_op[1:0], illegal}
  logic [15:0] dut_vec;
  assign dut_vec = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                    bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.pc_src, bus.alu_op, bus.illegal};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  // An instruction is FETCH, DECODE, then an opcode-specific list of steps.
  typedef enum {M_IDLE, M_FETCH, M_DEC, M_RALU, M_RWB, M_ADDR, M_LOAD, M_LWB,
                M_STORE, M_BR, M_IALU, M_IWB, M_JMP, M_BAD} step_t;

  step_t m_q[$];
  bit    m_valid = 1'b0;

  function automatic logic [15:0] expect_vec(input step_t s, input logic mr, input logic z);
    logic pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill;
    logic [1:0] srcb, pcs, aop;
    {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      M_FETCH: begin mrd = 1; irw = mr; pc_en = mr; srcb = 2'b01; end
      M_DEC:   srcb = 2'b11;
      M_RALU:  begin srca = 1; aop = 2'b10; end
      M_RWB:   begin rdst = 1; rw = 1; end
      M_ADDR:  begin srca = 1; srcb = 2'b10; end
      M_LOAD:  begin iord = 1; mrd = 1; end
      M_LWB:   begin m2r = 1; rw = 1; end
      M_STORE: begin iord = 1; mwr = 1; end
      M_BR:    begin srca = 1; aop = 2'b01; pcs = 2'b01; pc_en = z; end
      M_IALU:  begin srca = 1; srcb = 2'b10; end
      M_IWB:   rw = 1;
      M_JMP:   begin pcs = 2'b10; pc_en = 1; end
      M_BAD:   ill = 1;
      default: ;
    endcase
    return {pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, pcs, aop, ill};
  endfunction

  // Advance the model on each rising edge from the inputs held during the cycle
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_q.delete();
        m_q.push_back(M_IDLE);
        m_valid = 1'b1;
      end else if (m_valid) begin
        if (!((m_q[0] == M_FETCH || m_q[0] == M_LOAD || m_q[0] == M_STORE) && !bus.mem_ready)) begin
          if (m_q[0] == M_DEC) begin
            void'(m_q.pop_front());
            case (bus.opcode)
              6'b000000: begin m_q.push_back(M_RALU); m_q.push_back(M_RWB); end
              6'b100011: begin m_q.push_back(M_ADDR); m_q.push_back(M_LOAD); m_q.push_back(M_LWB); end
              6'b101011: begin m_q.push_back(M_ADDR); m_q.push_back(M_STORE); end
              6'b000100: m_q.push_back(M_BR);
              6'b001000: begin m_q.push_back(M_IALU); m_q.push_back(M_IWB); end
              6'b000010: m_q.push_back(M_JMP);
              default:   m_q.push_back(M_BAD);
            endcase
          end else begin
            void'(m_q.pop_front());
          end
          if (m_q.size() == 0) begin
            m_q.push_back(M_FETCH);
            m_q.push_back(M_DEC);
          end
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check($sformatf("model_cycle%0d", cyc), dut_vec, expect_vec(m_q[0], bus.mem_ready, bus.zero));
        check($sformatf("write_onehot_cycle%0d", cyc),
              ($countones({bus.reg_write, bus.mem_write, bus.ir_write}) <= 1), 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rn, input logic [5:0] op, input logic z, input logic mr);
    reset_n       = rn;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [5:0] op, input logic z, input logic mr, input int count);
    repeat (count) begin
      drive(1'b1, op, z, mr);
      tick();
    end
  endtask

  // FETCH signature: mem_read=1, iord=0, alu_src_b=01, no reg/mem write, no illegal
  task automatic check_fetch(input string name);
    check(name, {bus.mem_read, bus.iord, bus.alu_src_b, bus.reg_write, bus.mem_write, bus.illegal},
          7'b1_0_01_000);
  endtask

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  initial begin
    logic [5:0] bad_ops [4];
    bad_ops = '{6'b000001, 6'b100100, 6'b001001, 6'b111110};

    // Reset held for two edges, then one IDLE cycle, then FETCH
    drive(1'b0, OPC_R, 1'b0, 1'b1); tick();
    drive(1'b0, OPC_R, 1'b0, 1'b1); check("reset_all_zero", dut_vec, 16'h0000); tick();
    drive(1'b1, OPC_R, 1'b0, 1'b1); check("idle_all_zero", dut_vec, 16'h0000); tick();

    // R-type, no waits: FETCH, DECODE, EXEC, ALUWB
    drive(1'b1, OPC_R, 1'b0, 1'b1); check_fetch("r_fetch");
    check("r_fetch_ir_pc", {bus.ir_write, bus.pc_en}, 2'b11); tick();
    drive(1'b1, OPC_R, 1'b0, 1'b1); check("r_decode_srcb", bus.alu_src_b, 2'b11); tick();
    drive(1'b1, OPC_R, 1'b0, 1'b1);
    check("r_exec", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 5'b1_00_10); tick();
    drive(1'b1, OPC_R, 1'b0, 1'b1);
    check("r_wb", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 3'b110); tick();

    // LW with two wait cycles in FETCH and in MEMRD: 9 cycles in total
    drive(1'b1, OPC_LW, 1'b0, 1'b0); check_fetch("lw_fetch");
    check("lw_fetch_stall", {bus.ir_write, bus.pc_en}, 2'b00); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b0); check_fetch("lw_fetch_wait2"); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1); check("lw_fetch_go", {bus.ir_write, bus.pc_en}, 2'b11); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1);
    check("lw_addr", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 5'b1_10_00); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b0); check("lw_rd_wait", {bus.iord, bus.mem_read}, 2'b11); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b0); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1); check("lw_rd_go", {bus.iord, bus.mem_read}, 2'b11); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1);
    check("lw_wb", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 3'b101); tick();

    // SW, opcode bus changes to LW after DECODE; one wait cycle in MEMWR
    drive(1'b1, OPC_SW, 1'b0, 1'b1); check_fetch("sw_fetch"); tick();
    drive(1'b1, OPC_SW, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b0);
    check("sw_wait_write", {bus.mem_write, bus.iord, bus.mem_read}, 3'b110); tick();
    drive(1'b1, OPC_LW, 1'b0, 1'b1);
    check("sw_write_go", {bus.mem_write, bus.iord, bus.mem_read}, 3'b110); tick();

    // BEQ taken then not taken
    drive(1'b1, OPC_BEQ, 1'b1, 1'b1); check_fetch("beq1_fetch"); tick();
    drive(1'b1, OPC_BEQ, 1'b1, 1'b1); check("beq1_decode_pc_en", bus.pc_en, 1'b0); tick();
    drive(1'b1, OPC_BEQ, 1'b1, 1'b1);
    check("beq_taken", {bus.pc_en, bus.pc_src, bus.alu_op, bus.alu_src_a}, 6'b1_01_01_1); tick();
    drive(1'b1, OPC_BEQ, 1'b0, 1'b1); check_fetch("beq0_fetch"); tick();
    drive(1'b1, OPC_BEQ, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_BEQ, 1'b0, 1'b1);
    check("beq_not_taken", {bus.pc_en, bus.pc_src}, 3'b0_01); tick();

    // ADDI
    drive(1'b1, OPC_ADDI, 1'b0, 1'b1); check_fetch("addi_fetch"); tick();
    drive(1'b1, OPC_ADDI, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_ADDI, 1'b0, 1'b1);
    check("addi_ex", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 5'b1_10_00); tick();
    drive(1'b1, OPC_ADDI, 1'b0, 1'b1);
    check("addi_wb", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, 3'b100); tick();

    // J
    drive(1'b1, OPC_J, 1'b0, 1'b1); check_fetch("j_fetch"); tick();
    drive(1'b1, OPC_J, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_J, 1'b0, 1'b1); check("j_jump", {bus.pc_en, bus.pc_src}, 3'b1_10); tick();

    // Illegal opcode: single-cycle pulse, no writes even with zero=1
    drive(1'b1, OPC_BAD, 1'b1, 1'b1); check_fetch("bad_fetch"); tick();
    drive(1'b1, OPC_BAD, 1'b1, 1'b1); check("bad_decode_quiet", bus.illegal, 1'b0); tick();
    drive(1'b1, OPC_BAD, 1'b1, 1'b1);
    check("bad_pulse", {bus.illegal, bus.reg_write, bus.mem_write, bus.ir_write, bus.pc_en}, 5'b10000);
    tick();
    drive(1'b1, OPC_R, 1'b0, 1'b1); check_fetch("bad_pulse_ends"); tick();
    run(OPC_R, 1'b0, 1'b1, 3);

    // Further unsupported opcodes, checked by the model only
    for (int i = 0; i < 4; i++) run(bad_ops[i], 1'b0, 1'b1, 3);

    // Reset while MEMWR is stalled
    drive(1'b1, OPC_SW, 1'b0, 1'b1); check_fetch("rst_sw_fetch"); tick();
    drive(1'b1, OPC_SW, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_SW, 1'b0, 1'b1); tick();
    drive(1'b1, OPC_SW, 1'b0, 1'b0); check("rst_sw_waiting", bus.mem_write, 1'b1); tick();
    drive(1'b0, OPC_SW, 1'b0, 1'b0); check("rst_sw_still_writing", bus.mem_write, 1'b1); tick();
    drive(1'b1, OPC_SW, 1'b0, 1'b0); check("rst_sw_dropped", dut_vec, 16'h0000); tick();
    drive(1'b1, OPC_J, 1'b0, 1'b1); check_fetch("rst_refetch"); tick();
    run(OPC_J, 1'b0, 1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
